// File: rtl/neuron_accumulator.sv
// ---------------------------------------------------------------------------
// neuron_accumulator
//
// Purpose:
//   Collects N_INPUTS sign-magnitude product terms for one neuron lane.
//   It sums them in two's complement and adds a bias latched at start.
//   The sum is saturated to the 16-bit sign-magnitude range, optionally
//   clamped at zero (ReLU), and held behind a valid/ready output handshake.
//
// Parameters:
//   BITSIZE   word width (sign bit + magnitude)
//   FRAC      fractional bits of the fixed-point format (the datapath is
//             format-agnostic; only checked for plausibility)
//   N_INPUTS  product terms per neuron (>= 2)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      one-cycle pulse that begins a neuron; honoured only in IDLE
//   bias       sign-magnitude bias, sampled on the accepted start
//   relu_en    sampled on the accepted start; 1 clamps negative results to 0
//   in_valid   product term present on in_data
//   in_data    sign-magnitude product term
//   in_ready   high only while accumulating terms
//   out_valid  result available on out_data
//   out_data   sign-magnitude result, held until the next bias stage
//   out_ready  downstream accepts the result
//   busy       high in every state except IDLE
// ---------------------------------------------------------------------------
module neuron_accumulator #(
    parameter int BITSIZE  = 16,
    parameter int FRAC     = 11,
    parameter int N_INPUTS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BITSIZE-1:0] bias,
    input  logic               relu_en,
    input  logic               in_valid,
    input  logic [BITSIZE-1:0] in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [BITSIZE-1:0] out_data,
    input  logic               out_ready,
    output logic               busy
);

    // Counter only needs to reach N_INPUTS-1. The accumulator carries enough
    // headroom for N_INPUTS full-scale terms plus a full-scale bias, so no
    // intermediate overflow is possible before saturation.
    localparam int CNT_W = $clog2(N_INPUTS);
    localparam int ACC_W = BITSIZE + CNT_W + 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (BITSIZE - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX;
    localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(N_INPUTS - 1);

    // Reject parameter sets the datapath cannot represent sensibly.
    if (N_INPUTS < 2 || FRAC >= BITSIZE - 1 || FRAC < 0) begin : g_bad_params
        $error("neuron_accumulator: invalid parameters");
    end

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        BIAS,
        OUT
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        count;
    logic [BITSIZE-1:0]      bias_q;
    logic                    relu_q;

    logic signed [ACC_W-1:0] term_val;
    logic signed [ACC_W-1:0] biased;
    logic signed [ACC_W-1:0] clipped;
    logic [BITSIZE-1:0]      result_sm;

    // Sign-magnitude to two's complement. Negative zero maps to 0 naturally
    // because negating a zero magnitude yields zero.
    function automatic logic signed [ACC_W-1:0] sm_to_twos(input logic [BITSIZE-1:0] v);
        logic signed [ACC_W-1:0] mag;
        mag = signed'(ACC_W'(v[BITSIZE-2:0]));
        return v[BITSIZE-1] ? -mag : mag;
    endfunction

    // State register; reset aborts any neuron in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. start is only looked at in IDLE, so a start pulse
    // arriving together with out_ready in OUT is dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (in_valid && count == LAST_CNT) state_next = BIAS;
            BIAS:    state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and status outputs follow directly from the state register.
    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == OUT);
        busy      = (state != IDLE);
    end

    // Bias stage: add bias, saturate to the symmetric sign-magnitude range,
    // apply ReLU, then re-encode. A non-negative value always takes the
    // positive encoding, so zero is emitted as all-zeros, never as -0.
    always_comb begin
        term_val = sm_to_twos(in_data);
        biased   = acc + sm_to_twos(bias_q);
        clipped  = biased;
        if (biased > SAT_MAX) begin
            clipped = SAT_MAX;
        end else if (biased < SAT_MIN) begin
            clipped = SAT_MIN;
        end
        if (relu_q && clipped < 0) begin
            clipped = '0;
        end
        if (clipped < 0) begin
            result_sm = {1'b1, (BITSIZE-1)'(-clipped)};
        end else begin
            result_sm = {1'b0, (BITSIZE-1)'(clipped)};
        end
    end

    // Datapath registers. The bias and ReLU mode are captured with the
    // accepted start; out_data only changes in the bias stage so it stays
    // stable through OUT and after the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            count    <= '0;
            bias_q   <= '0;
            relu_q   <= 1'b0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bias_q <= bias;
                        relu_q <= relu_en;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc   <= acc + term_val;
                        count <= count + CNT_W'(1);
                    end
                end
                BIAS: begin
                    out_data <= result_sm;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_accumulator.sv
// ---------------------------------------------------------------------------
// tb_neuron_accumulator
//
// Purpose:
//   Directed self-checking bench for neuron_accumulator with N_INPUTS = 4.
//   Expected results are hand-computed sign-magnitude constants.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_neuron_accumulator;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bias;
    logic        relu_en;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    neuron_accumulator #(
        .BITSIZE (16),
        .FRAC    (11),
        .N_INPUTS(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bias     (bias),
        .relu_en  (relu_en),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .busy     (busy)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to 1 ns after the next rising edge; inputs are driven and
    // outputs sampled there, away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One comparison point.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Starts a neuron and feeds four back-to-back terms. Returns in the bias
    // cycle (one cycle after the last term was accepted).
    task automatic applyStimulus(input logic [15:0] b, input logic r,
                                 input logic [15:0] t0, input logic [15:0] t1,
                                 input logic [15:0] t2, input logic [15:0] t3);
        logic [15:0] terms [4];
        terms[0] = t0;
        terms[1] = t1;
        terms[2] = t2;
        terms[3] = t3;
        start   = 1'b1;
        bias    = b;
        relu_en = r;
        tick();
        start   = 1'b0;
        bias    = 16'h5555;
        relu_en = ~r;
        checkOutput("start_in_ready", {15'd0, in_ready}, 16'd1);
        checkOutput("start_busy", {15'd0, busy}, 16'd1);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = terms[i];
            tick();
        end
        in_valid = 1'b0;
        in_data  = 16'h0000;
        checkOutput("bias_in_ready", {15'd0, in_ready}, 16'd0);
        checkOutput("bias_out_valid", {15'd0, out_valid}, 16'd0);
    endtask

    // From the bias cycle: check the result appears, then complete the
    // handshake and check the return to IDLE with the result held.
    task automatic collectResult(input string tag, input logic [15:0] expected);
        tick();
        checkOutput({tag, "_valid"}, {15'd0, out_valid}, 16'd1);
        checkOutput(tag, out_data, expected);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput({tag, "_valid_drop"}, {15'd0, out_valid}, 16'd0);
        checkOutput({tag, "_idle"}, {15'd0, busy}, 16'd0);
        checkOutput({tag, "_held"}, out_data, expected);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        bias      = 16'h0000;
        relu_en   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;
        tick();
        tick();
        checkOutput("rst_out_valid", {15'd0, out_valid}, 16'd0);
        checkOutput("rst_out_data", out_data, 16'h0000);
        checkOutput("rst_in_ready", {15'd0, in_ready}, 16'd0);
        checkOutput("rst_busy", {15'd0, busy}, 16'd0);
        rst = 1'b0;
        tick();

        // 4 x 1.0 + 0 = 4.0
        applyStimulus(16'h0000, 1'b0, 16'h0800, 16'h0800, 16'h0800, 16'h0800);
        collectResult("sum_pos", 16'h2000);

        // 4 x -1.0 + 0.5 = -3.5, then the same with ReLU clamps to 0
        applyStimulus(16'h0400, 1'b0, 16'h8800, 16'h8800, 16'h8800, 16'h8800);
        collectResult("sum_neg", 16'h9C00);
        applyStimulus(16'h0400, 1'b1, 16'h8800, 16'h8800, 16'h8800, 16'h8800);
        collectResult("relu_clamp", 16'h0000);

        // Saturation in both directions and negative-zero inputs
        applyStimulus(16'h7FFF, 1'b0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        collectResult("sat_pos", 16'h7FFF);
        applyStimulus(16'hFFFF, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        collectResult("sat_neg", 16'hFFFF);
        applyStimulus(16'h8000, 1'b0, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
        collectResult("neg_zero", 16'h0000);

        // in_valid in IDLE must be ignored
        in_valid = 1'b1;
        in_data  = 16'h7FFF;
        tick();
        tick();
        checkOutput("idle_ignore_busy", {15'd0, busy}, 16'd0);
        checkOutput("idle_ignore_in_ready", {15'd0, in_ready}, 16'd0);
        in_valid = 1'b0;

        // Terms with gaps: 1, gap 3, 1, gap 1, 1, 1
        start = 1'b1;
        bias  = 16'h0000;
        relu_en = 1'b0;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h0800;
        tick();
        in_valid = 1'b0;
        in_data  = 16'h7FFF;
        tick();
        tick();
        tick();
        checkOutput("gap_still_accum", {15'd0, in_ready}, 16'd1);
        in_valid = 1'b1;
        in_data  = 16'h0800;
        tick();
        in_valid = 1'b0;
        in_data  = 16'h7FFF;
        tick();
        in_valid = 1'b1;
        in_data  = 16'h0800;
        tick();
        checkOutput("gap_third_accum", {15'd0, in_ready}, 16'd1);
        tick();
        in_valid = 1'b0;
        checkOutput("gap_bias_in_ready", {15'd0, in_ready}, 16'd0);
        tick();
        checkOutput("gap_result", out_data, 16'h2000);

        // Backpressure: result held for 5 cycles, start pulses ignored
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0);
            bias  = 16'h7FFF;
            tick();
            checkOutput("bp_out_valid", {15'd0, out_valid}, 16'd1);
            checkOutput("bp_out_data", out_data, 16'h2000);
            checkOutput("bp_busy", {15'd0, busy}, 16'd1);
        end
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        checkOutput("bp_release_busy", {15'd0, busy}, 16'd0);
        checkOutput("bp_start_dropped", {15'd0, in_ready}, 16'd0);

        // New neuron right after the handshake: 4 x 0.5 + 1.0 = 3.0
        applyStimulus(16'h0800, 1'b0, 16'h0400, 16'h0400, 16'h0400, 16'h0400);
        collectResult("after_bp", 16'h1800);

        // Reset after two terms aborts the neuron asynchronously
        start = 1'b1;
        bias  = 16'h7FFF;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h7FFF;
        tick();
        tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_in_ready", {15'd0, in_ready}, 16'd0);
        checkOutput("abort_busy", {15'd0, busy}, 16'd0);
        checkOutput("abort_out_valid", {15'd0, out_valid}, 16'd0);
        checkOutput("abort_out_data", out_data, 16'h0000);
        tick();
        #2;
        rst = 1'b0;
        tick();
        applyStimulus(16'h0000, 1'b0, 16'h0800, 16'h0800, 16'h0800, 16'h0800);
        collectResult("after_abort", 16'h2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
